branch_predictor: RTL and testbench

- Dynamic branch predictor and resolve unit for the dual-issue RV32I core.
- Sits around the EX-stage branch judge:
  - IF side: combinational lookups for both fetch slots from a direct-mapped BHT of 2-bit saturating counters plus a tagged BTB.
  - EX side: consumes the judge's is_branch/is_jump/taken/target_pc, trains the tables and raises a registered flush/redirect on misprediction.

---
 rtl/branch_predictor_pkg.sv | 16 +
 rtl/branch_predictor_if.sv | 45 ++++
 rtl/branch_predictor_sat_counter.sv | 21 ++
 rtl/branch_predictor.sv | 152 +++++++++++++++
 tb/tb_branch_predictor.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch predictor: RV32I control-flow opcodes
// and the 2-bit saturating counter encodings.
package branch_predictor_pkg;

   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } cnt_e;

endpackage

// File: rtl/branch_predictor_if.sv
// Core-side bundle for the branch predictor: two fetch-slot lookups, the EX
// resolve bus, and the flush/redirect and performance outputs.
interface branch_predictor_if;

   // The EX bus has no ready: ex_valid qualifies every ex_* field and is
   // consumed in the cycle it is high; flush/redirect_pc are meaningful only
   // while flush=1.
   logic [31:0] if_pc0;
   logic [31:0] if_pc1;
   logic        pred_taken0;
   logic        pred_taken1;
   logic [31:0] pred_target0;
   logic [31:0] pred_target1;

   logic        ex_valid;
   logic [31:0] ex_pc;
   logic        ex_is_branch;
   logic        ex_is_jump;
   logic        ex_taken;
   logic [31:0] ex_target;
   logic        ex_pred_taken;
   logic [31:0] ex_pred_target;

   logic        flush;
   logic [31:0] redirect_pc;
   logic [31:0] branch_cnt;
   logic [31:0] mispred_cnt;

   modport master (
      output if_pc0, if_pc1,
      output ex_valid, ex_pc, ex_is_branch, ex_is_jump, ex_taken, ex_target,
      output ex_pred_taken, ex_pred_target,
      input  pred_taken0, pred_taken1, pred_target0, pred_target1,
      input  flush, redirect_pc, branch_cnt, mispred_cnt
   );

   modport slave (
      input  if_pc0, if_pc1,
      input  ex_valid, ex_pc, ex_is_branch, ex_is_jump, ex_taken, ex_target,
      input  ex_pred_taken, ex_pred_target,
      output pred_taken0, pred_taken1, pred_target0, pred_target1,
      output flush, redirect_pc, branch_cnt, mispred_cnt
   );

endinterface

// File: rtl/branch_predictor_sat_counter.sv
// Next-state function of a 2-bit saturating taken/not-taken counter.
module bp_sat_counter
   import branch_predictor_pkg::*;
(
   input  cnt_e cnt_i,
   input  logic inc_i,
   output cnt_e cnt_o
);

   always_comb begin
      cnt_o = cnt_i;
      case (cnt_i)
         SNT:     cnt_o = inc_i ? WNT : SNT;
         WNT:     cnt_o = inc_i ? WT  : SNT;
         WT:      cnt_o = inc_i ? ST  : WNT;
         ST:      cnt_o = inc_i ? ST  : WT;
         default: cnt_o = cnt_i;
      endcase
   end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BHT + tagged BTB with dual-slot combinational lookup, EX-side
// training, registered flush/redirect on mispredict and perf counters.
module branch_predictor
   import branch_predictor_pkg::*;
#(
   parameter int   INDEX_BITS = 6,
   parameter int   TAG_BITS   = 30 - INDEX_BITS,
   parameter cnt_e CNT_INIT   = WNT
)
(
   input  logic             clk,
   input  logic             rst_n,
   branch_predictor_if.slave bp
);

   localparam int ENTRIES = 1 << INDEX_BITS;

   typedef logic [INDEX_BITS-1:0] idx_t;
   typedef logic [TAG_BITS-1:0]   tag_t;

   logic        valid_q  [ENTRIES];
   logic        valid_d  [ENTRIES];
   tag_t        tag_q    [ENTRIES];
   tag_t        tag_d    [ENTRIES];
   logic [31:0] target_q [ENTRIES];
   logic [31:0] target_d [ENTRIES];
   logic        is_jmp_q [ENTRIES];
   logic        is_jmp_d [ENTRIES];
   cnt_e        cnt_q    [ENTRIES];
   cnt_e        cnt_d    [ENTRIES];

   logic        flush_q, flush_d;
   logic [31:0] redirect_q, redirect_d;
   logic [31:0] branch_cnt_q, branch_cnt_d;
   logic [31:0] mispred_cnt_q, mispred_cnt_d;

   // Lookups read the registered tables, so a same-cycle update is not visible.
   idx_t lk_idx0, lk_idx1;
   tag_t lk_tag0, lk_tag1;
   logic lk_hit0, lk_hit1;

   assign lk_idx0 = bp.if_pc0[INDEX_BITS+1:2];
   assign lk_idx1 = bp.if_pc1[INDEX_BITS+1:2];
   assign lk_tag0 = bp.if_pc0[31:INDEX_BITS+2];
   assign lk_tag1 = bp.if_pc1[31:INDEX_BITS+2];
   assign lk_hit0 = valid_q[lk_idx0] && (tag_q[lk_idx0] == lk_tag0);
   assign lk_hit1 = valid_q[lk_idx1] && (tag_q[lk_idx1] == lk_tag1);

   assign bp.pred_taken0  = lk_hit0 && (is_jmp_q[lk_idx0] || cnt_q[lk_idx0][1]);
   assign bp.pred_taken1  = lk_hit1 && (is_jmp_q[lk_idx1] || cnt_q[lk_idx1][1]);
   assign bp.pred_target0 = bp.pred_taken0 ? target_q[lk_idx0] : 32'd0;
   assign bp.pred_target1 = bp.pred_taken1 ? target_q[lk_idx1] : 32'd0;

   // EX-side resolve decode
   idx_t ex_idx;
   tag_t ex_tag;
   logic ex_hit;
   logic ex_ctrl;
   logic ex_upd;
   logic ex_actual;
   logic ex_mp;
   cnt_e cnt_next;

   assign ex_idx    = bp.ex_pc[INDEX_BITS+1:2];
   assign ex_tag    = bp.ex_pc[31:INDEX_BITS+2];
   assign ex_hit    = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
   assign ex_ctrl   = bp.ex_is_branch || bp.ex_is_jump;
   assign ex_upd    = bp.ex_valid && ex_ctrl;
   assign ex_actual = ex_ctrl && bp.ex_taken;
   assign ex_mp     = bp.ex_valid &&
                      ((ex_actual != bp.ex_pred_taken) ||
                       (ex_actual && (bp.ex_target != bp.ex_pred_target)));

   bp_sat_counter u_sat_counter (
      .cnt_i (cnt_q[ex_idx]),
      .inc_i (bp.ex_taken),
      .cnt_o (cnt_next)
   );

   always_comb begin
      valid_d  = valid_q;
      tag_d    = tag_q;
      target_d = target_q;
      is_jmp_d = is_jmp_q;
      cnt_d    = cnt_q;
      if (ex_upd) begin
         if (bp.ex_is_jump) begin
            valid_d[ex_idx]  = 1'b1;
            tag_d[ex_idx]    = ex_tag;
            target_d[ex_idx] = bp.ex_target;
            is_jmp_d[ex_idx] = 1'b1;
            cnt_d[ex_idx]    = ST;
         end else if (ex_hit) begin
            cnt_d[ex_idx] = cnt_next;
            if (bp.ex_taken) begin
               target_d[ex_idx] = bp.ex_target;
            end
         end else if (bp.ex_taken) begin
            valid_d[ex_idx]  = 1'b1;
            tag_d[ex_idx]    = ex_tag;
            target_d[ex_idx] = bp.ex_target;
            is_jmp_d[ex_idx] = 1'b0;
            cnt_d[ex_idx]    = WT;
         end
      end else if (bp.ex_valid && bp.ex_pred_taken && ex_hit) begin
         // A non-control instruction hit a taken entry: the entry belongs to
         // an aliasing pc, so drop it rather than keep mispredicting.
         valid_d[ex_idx] = 1'b0;
      end
   end

   always_comb begin
      flush_d       = ex_mp;
      redirect_d    = ex_actual ? bp.ex_target : (bp.ex_pc + 32'd4);
      branch_cnt_d  = branch_cnt_q + {31'd0, ex_upd};
      mispred_cnt_d = mispred_cnt_q + {31'd0, ex_mp};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q       <= '{default: 1'b0};
         tag_q         <= '{default: '0};
         target_q      <= '{default: 32'd0};
         is_jmp_q      <= '{default: 1'b0};
         cnt_q         <= '{default: CNT_INIT};
         flush_q       <= 1'b0;
         redirect_q    <= 32'd0;
         branch_cnt_q  <= 32'd0;
         mispred_cnt_q <= 32'd0;
      end else begin
         valid_q       <= valid_d;
         tag_q         <= tag_d;
         target_q      <= target_d;
         is_jmp_q      <= is_jmp_d;
         cnt_q         <= cnt_d;
         flush_q       <= flush_d;
         redirect_q    <= redirect_d;
         branch_cnt_q  <= branch_cnt_d;
         mispred_cnt_q <= mispred_cnt_d;
      end
   end

   assign bp.flush       = flush_q;
   assign bp.redirect_pc = redirect_q;
   assign bp.branch_cnt  = branch_cnt_q;
   assign bp.mispred_cnt = mispred_cnt_q;

   // Fetch pc byte-offset bits and the shared opcode constants have no role here.
   logic unused_bits;
   assign unused_bits = ^{bp.if_pc0[1:0], bp.if_pc1[1:0], OP_JAL, OP_JALR, OP_BRANCH};

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: EX resolves push expected flush/redirect into a
// queue that is popped one cycle later; lookups are checked against constants.
module tb_branch_predictor;

   logic clk;
   logic rst_n;

   branch_predictor_if bp_if ();

   branch_predictor dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bp    (bp_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int br_exp   = 0;
   int mp_exp   = 0;
   logic [32:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end else begin
         n_pass++;
      end
   endtask

   task automatic lookup(input logic [31:0] pc0, input logic e_tk0, input logic [31:0] e_t0,
                         input logic [31:0] pc1, input logic e_tk1, input logic [31:0] e_t1);
      bp_if.if_pc0 = pc0;
      bp_if.if_pc1 = pc1;
      #1;
      check("pred_taken0", {31'd0, bp_if.pred_taken0}, {31'd0, e_tk0});
      check("pred_target0", bp_if.pred_target0, e_t0);
      check("pred_taken1", {31'd0, bp_if.pred_taken1}, {31'd0, e_tk1});
      check("pred_target1", bp_if.pred_target1, e_t1);
   endtask

   // Drives one resolve; optionally checks that a same-cycle slot-0 lookup
   // still sees the pre-update table.
   task automatic resolve(input logic [31:0] pc, input logic br, input logic jmp,
                          input logic tk, input logic [31:0] tgt,
                          input logic ptk, input logic [31:0] ptgt,
                          input logic e_flush, input logic [31:0] e_redir,
                          input logic rdw_chk, input logic rdw_exp);
      logic [32:0] e;
      @(negedge clk);
      bp_if.ex_valid       = 1'b1;
      bp_if.ex_pc          = pc;
      bp_if.ex_is_branch   = br;
      bp_if.ex_is_jump     = jmp;
      bp_if.ex_taken       = tk;
      bp_if.ex_target      = tgt;
      bp_if.ex_pred_taken  = ptk;
      bp_if.ex_pred_target = ptgt;
      exp_q.push_back({e_flush, e_redir});
      if (br || jmp) br_exp++;
      if (e_flush) mp_exp++;
      #1;
      if (rdw_chk) check("rdw_pred", {31'd0, bp_if.pred_taken0}, {31'd0, rdw_exp});
      @(posedge clk);
      #1;
      bp_if.ex_valid = 1'b0;
      e = exp_q.pop_front();
      check("flush", {31'd0, bp_if.flush}, {31'd0, e[32]});
      if (e[32]) check("redirect", bp_if.redirect_pc, e[31:0]);
      check("branch_cnt", bp_if.branch_cnt, br_exp);
      check("mispred_cnt", bp_if.mispred_cnt, mp_exp);
   endtask

   task automatic idle_cycle();
      @(negedge clk);
      @(posedge clk);
      #1;
      check("flush_pulse_end", {31'd0, bp_if.flush}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] rpc;
      int kind;
      rst_n = 1'b0;
      bp_if.if_pc0 = 32'h100;
      bp_if.if_pc1 = 32'h104;
      bp_if.ex_valid = 1'b0;
      bp_if.ex_pc = 32'd0;
      bp_if.ex_is_branch = 1'b0;
      bp_if.ex_is_jump = 1'b0;
      bp_if.ex_taken = 1'b0;
      bp_if.ex_target = 32'd0;
      bp_if.ex_pred_taken = 1'b0;
      bp_if.ex_pred_target = 32'd0;
      @(negedge clk);
      @(negedge clk);
      check("rst_flush", {31'd0, bp_if.flush}, 32'd0);
      check("rst_redirect", bp_if.redirect_pc, 32'd0);
      check("rst_branch_cnt", bp_if.branch_cnt, 32'd0);
      check("rst_mispred_cnt", bp_if.mispred_cnt, 32'd0);
      lookup(32'h100, 1'b0, 32'd0, 32'h104, 1'b0, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Taken beq allocates with WT and predicts taken next cycle.
      bp_if.if_pc0 = 32'h100;
      resolve(32'h100, 1, 0, 1, 32'h80, 0, 32'd0, 1, 32'h80, 1, 0);
      lookup(32'h100, 1'b1, 32'h80, 32'h104, 1'b0, 32'd0);
      idle_cycle();

      // Three not-taken resolves back-to-back: 10->01->00->00.
      resolve(32'h100, 1, 0, 0, 32'h80, 1, 32'h80, 1, 32'h104, 0, 0);
      resolve(32'h100, 1, 0, 0, 32'h80, 1, 32'h80, 1, 32'h104, 0, 0);
      resolve(32'h100, 1, 0, 0, 32'h80, 0, 32'd0, 0, 32'd0, 0, 0);
      lookup(32'h100, 1'b0, 32'd0, 32'h104, 1'b0, 32'd0);
      // One taken from the floor only reaches WNT.
      resolve(32'h100, 1, 0, 1, 32'h80, 0, 32'd0, 1, 32'h80, 0, 0);
      lookup(32'h100, 1'b0, 32'd0, 32'h104, 1'b0, 32'd0);

      // jal at 0x200 shares index 0; pre-update lookup still misses.
      bp_if.if_pc0 = 32'h200;
      resolve(32'h200, 0, 1, 1, 32'h400, 0, 32'd0, 1, 32'h400, 1, 0);
      lookup(32'h200, 1'b1, 32'h400, 32'h100, 1'b0, 32'd0);
      resolve(32'h200, 0, 1, 1, 32'h400, 1, 32'h400, 0, 32'd0, 0, 0);
      idle_cycle();

      // jalr with a stale target.
      resolve(32'h300, 0, 1, 1, 32'h600, 1, 32'h500, 1, 32'h600, 0, 0);
      lookup(32'h300, 1'b1, 32'h600, 32'h200, 1'b0, 32'd0);

      // Alias scrub at 0x1100 (index 0).
      resolve(32'h1100, 1, 0, 1, 32'h2000, 0, 32'd0, 1, 32'h2000, 0, 0);
      lookup(32'h1100, 1'b1, 32'h2000, 32'h300, 1'b0, 32'd0);
      resolve(32'h1100, 0, 0, 0, 32'd0, 1, 32'h2000, 1, 32'h1104, 0, 0);
      lookup(32'h1100, 1'b0, 32'd0, 32'h100, 1'b0, 32'd0);

      // Upper saturation and target kept on a not-taken hit.
      resolve(32'h40, 1, 0, 1, 32'h10, 0, 32'd0, 1, 32'h10, 0, 0);
      resolve(32'h40, 1, 0, 1, 32'h10, 1, 32'h10, 0, 32'd0, 0, 0);
      resolve(32'h40, 1, 0, 1, 32'h10, 1, 32'h10, 0, 32'd0, 0, 0);
      resolve(32'h40, 1, 0, 0, 32'h999c, 1, 32'h10, 1, 32'h44, 0, 0);
      lookup(32'h40, 1'b1, 32'h10, 32'h44, 1'b0, 32'd0);

      // pc+4 wraps at the top of the address space.
      resolve(32'hFFFF_FFFC, 0, 0, 0, 32'd0, 1, 32'h8, 1, 32'h0, 0, 0);

      // Random pcs in a region with no live entries.
      for (int i = 0; i < 8; i++) begin
         rpc = 32'h10000 + ({18'd0, 14'($urandom_range(0, 16383))} << 2);
         kind = $urandom_range(0, 2);
         if (kind == 0)
            resolve(rpc, 0, 0, 0, 32'd0, 0, 32'd0, 0, 32'd0, 0, 0);
         else if (kind == 1)
            resolve(rpc, 1, 0, 0, rpc + 32'h40, 0, 32'd0, 0, 32'd0, 0, 0);
         else
            resolve(rpc, 0, 0, 0, 32'd0, 1, rpc + 32'h40, 1, rpc + 32'd4, 0, 0);
         lookup(rpc, 1'b0, 32'd0, rpc + 32'd4, 1'b0, 32'd0);
      end

      // Reset during a flush pulse clears everything at once.
      resolve(32'h200, 0, 1, 1, 32'h400, 0, 32'd0, 1, 32'h400, 0, 0);
      rst_n = 1'b0;
      #1;
      check("arst_flush", {31'd0, bp_if.flush}, 32'd0);
      check("arst_redirect", bp_if.redirect_pc, 32'd0);
      check("arst_branch_cnt", bp_if.branch_cnt, 32'd0);
      check("arst_mispred_cnt", bp_if.mispred_cnt, 32'd0);
      lookup(32'h200, 1'b0, 32'd0, 32'h40, 1'b0, 32'd0);
      br_exp = 0;
      mp_exp = 0;
      @(negedge clk);
      rst_n = 1'b1;
      resolve(32'h500, 1, 0, 1, 32'h700, 0, 32'd0, 1, 32'h700, 0, 0);
      lookup(32'h500, 1'b1, 32'h700, 32'h504, 1'b0, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
